// File: rtl/datapath_core_p.sv
// Datapath core for the multicycle CPU: register file, ALU, PC, IR, status
// flags and a req/ack memory port with stall and timeout abort.
//
// state  | meaning
// S_IDLE | no access outstanding, or a zero-wait access
// S_WAIT | memory access stalled, waiting for ack or timeout
module datapath_core_p #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 32,
    parameter int NREG    = 32,
    parameter int RA_W    = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              as,
    input  logic [1:0]        ds,
    input  logic [1:0]        ps,
    input  logic              pc_sel,
    input  logic              k_sel,
    input  logic              il,
    input  logic              sl,
    input  logic [3:0]        fs,
    input  logic              c0,
    input  logic              mw,
    input  logic              rw,
    input  logic [RA_W-1:0]   da,
    input  logic [RA_W-1:0]   sa,
    input  logic [RA_W-1:0]   sb,
    input  logic [DATA_W-1:0] k,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        sf,
    output logic [31:0]       ir_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              busy,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  regs_q [NREG];
    logic [DATA_W-1:0]  regs_d [NREG];
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [31:0]        ir_q, ir_d;
    logic [3:0]         sf_q, sf_d;
    logic               bus_err_q, bus_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [DATA_W-1:0]  a_bus, b_bus, b_op, add_b, alu_r, mem_data, d_bus;
    logic [DATA_W:0]    sum;
    logic               alu_c, alu_v;
    logic [3:0]         flags;
    logic [ADDR_W-1:0]  pc_in, pc_next;
    logic               mem_op, abort, commit;

    assign a_bus = (sa == '0) ? '0 : regs_q[sa];
    assign b_bus = (sb == '0) ? '0 : regs_q[sb];
    assign b_op  = k_sel ? k : b_bus;

    always_comb begin
        add_b = (fs == 4'd5) ? ~b_op : b_op;
        sum   = {1'b0, a_bus} + {1'b0, add_b} + {{DATA_W{1'b0}}, c0};
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (fs)
            4'd0: alu_r = a_bus & b_op;
            4'd1: alu_r = a_bus | b_op;
            4'd2: alu_r = a_bus ^ b_op;
            4'd3: alu_r = ~a_bus;
            4'd4, 4'd5: begin
                alu_r = sum[DATA_W-1:0];
                alu_c = sum[DATA_W];
                alu_v = (a_bus[DATA_W-1] == add_b[DATA_W-1]) &&
                        (sum[DATA_W-1] != a_bus[DATA_W-1]);
            end
            4'd6: alu_r = a_bus << 1;
            4'd7: alu_r = a_bus >> 1;
            4'd8: alu_r = b_op;
            default: alu_r = '0;
        endcase
        flags = {alu_v, alu_c, alu_r[DATA_W-1], alu_r == '0};
    end

    // Abort only from WAIT: the IDLE cycle of a stall already counts as one wait.
    assign mem_op   = (ds == 2'b11) | mw;
    assign abort    = (state_q == S_WAIT) & mem_op & ~mem_ack & (cnt_q == TO_V);
    assign commit   = ~mem_op | mem_ack | abort;
    assign busy     = mem_op & ~mem_ack & ~abort;
    assign mem_req  = mem_op & ~abort;
    assign mem_we   = mw;
    assign mem_data = abort ? '1 : mem_rdata;
    assign mem_addr = as ? alu_r[ADDR_W-1:0] : pc_q;
    assign mem_wdata = b_bus;

    always_comb begin
        case (ds)
            2'b00:   d_bus = alu_r;
            2'b01:   d_bus = b_bus;
            2'b10:   d_bus = DATA_W'(pc_q);
            default: d_bus = mem_data;
        endcase
    end

    assign pc_in = pc_sel ? k[ADDR_W-1:0] : a_bus[ADDR_W-1:0];

    always_comb begin
        case (ps)
            2'b00:   pc_next = pc_q;
            2'b01:   pc_next = pc_q + ADDR_W'(4);
            2'b10:   pc_next = pc_in;
            default: pc_next = pc_q + ADDR_W'(4) + (pc_in << 2);
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (mem_op & ~mem_ack) state_d = S_WAIT;
            S_WAIT: if (commit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        regs_d    = regs_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        sf_d      = sf_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q | abort;
        if (commit) begin
            if (rw && (da != '0)) regs_d[da] = d_bus;
            if (il) ir_d = d_bus[31:0];
            if (sl) sf_d = flags;
            pc_d  = pc_next;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            sf_q      <= '0;
            bus_err_q <= 1'b0;
            cnt_q     <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            sf_q      <= sf_d;
            bus_err_q <= bus_err_d;
            cnt_q     <= cnt_d;
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign sf      = sf_q;
    assign ir_out  = ir_q;
    assign pc_out  = pc_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_datapath_core_p.sv
// Bench for datapath_core_p: ALU vector table, directed memory/timeout/reset
// sequences, then random instructions against a behavioural model.
module tb_datapath_core_p;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        as_s;
    logic [1:0]  ds, ps;
    logic        pc_sel, k_sel, il, sl, c0, mw, rw, mem_ack;
    logic [3:0]  fs;
    logic [4:0]  da, sa, sb;
    logic [63:0] k, mem_rdata;
    logic        mem_req, mem_we, busy, bus_err;
    logic [31:0] mem_addr, ir_out, pc_out;
    logic [63:0] mem_wdata;
    logic [3:0]  sf;

    int tests = 0;
    int fails = 0;

    datapath_core_p dut (
        .clk(clk), .rst(rst), .as(as_s), .ds(ds), .ps(ps), .pc_sel(pc_sel),
        .k_sel(k_sel), .il(il), .sl(sl), .fs(fs), .c0(c0), .mw(mw), .rw(rw),
        .da(da), .sa(sa), .sb(sb), .k(k), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .sf(sf), .ir_out(ir_out),
        .pc_out(pc_out), .busy(busy), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  fs;
        logic [63:0] a;
        logic [63:0] b;
        logic        c0;
        logic [63:0] r;
        logic [3:0]  f;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        as_s = 0; ds = 0; ps = 0; pc_sel = 0; k_sel = 0; il = 0; sl = 0;
        fs = 0; c0 = 0; mw = 0; rw = 0; da = 0; sa = 0; sb = 0; k = 0;
        mem_rdata = 0; mem_ack = 0;
    endtask

    task automatic wr_k(input logic [4:0] r, input logic [63:0] v);
        idle();
        k = v; k_sel = 1; fs = 4'd8; rw = 1; da = r;
        step();
        idle();
    endtask

    task automatic rd(input string nm, input logic [4:0] r, input logic [63:0] e);
        sb = r;
        #1;
        chk(nm, mem_wdata, e);
    endtask

    // Reference ALU from arithmetic definitions: carry from unsigned range,
    // overflow from the exact signed result falling outside 64-bit range.
    function automatic void alu_m(input logic [63:0] a, input logic [63:0] b,
                                  input logic [3:0] f, input logic ci,
                                  output logic [63:0] r, output logic [3:0] fl);
        logic [64:0] u;
        logic signed [66:0] s, hi, lo, sa_x, sb_x, ci_x;
        logic v, c;
        hi   = 67'sh7FFF_FFFF_FFFF_FFFF;
        lo   = -hi - 67'sd1;
        sa_x = {{3{a[63]}}, a};
        sb_x = {{3{b[63]}}, b};
        ci_x = {66'd0, ci};
        v = 0; c = 0;
        case (f)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a ^ b;
            4'd3: r = ~a;
            4'd4: begin
                u = {1'b0, a} + {1'b0, b} + {64'd0, ci};
                r = u[63:0];
                c = u[64];
                s = sa_x + sb_x + ci_x;
                v = (s > hi) || (s < lo);
            end
            4'd5: begin
                r = a - b - 64'd1 + {63'd0, ci};
                c = ({1'b0, a} + {64'd0, ci}) > {1'b0, b};
                s = sa_x - sb_x - 67'sd1 + ci_x;
                v = (s > hi) || (s < lo);
            end
            4'd6: r = a * 2;
            4'd7: r = a / 2;
            4'd8: r = b;
            default: r = 0;
        endcase
        fl = {v, c, r[63], r == 64'd0};
    endfunction

    logic [63:0] m_regs [32];
    logic [31:0] m_pc, m_ir;
    logic [3:0]  m_sf;
    logic        m_err;

    initial begin
        vecs[0]  = '{4'd4, 64'd5, 64'd5, 1'b0, 64'd10, 4'b0000};
        vecs[1]  = '{4'd5, 64'd5, 64'd5, 1'b1, 64'd0, 4'b0101};
        vecs[2]  = '{4'd4, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1010};
        vecs[3]  = '{4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b0101};
        vecs[4]  = '{4'd0, 64'hF0F0, 64'hFF00, 1'b0, 64'hF000, 4'b0000};
        vecs[5]  = '{4'd1, 64'hF0F0, 64'hFF00, 1'b0, 64'hFFF0, 4'b0000};
        vecs[6]  = '{4'd2, 64'hF0F0, 64'hFF00, 1'b0, 64'h0FF0, 4'b0000};
        vecs[7]  = '{4'd3, 64'd0, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010};
        vecs[8]  = '{4'd6, 64'h8000_0000_0000_0001, 64'd0, 1'b0, 64'd2, 4'b0000};
        vecs[9]  = '{4'd7, 64'h8000_0000_0000_0001, 64'd0, 1'b0, 64'h4000_0000_0000_0000, 4'b0000};
        vecs[10] = '{4'd8, 64'd7, 64'd0, 1'b0, 64'd0, 4'b0001};
        vecs[11] = '{4'd5, 64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010};
        vecs[12] = '{4'd5, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1100};

        idle();
        #12;
        chk("reset_pc", pc_out, 0);
        chk("reset_ir", ir_out, 0);
        chk("reset_sf", sf, 0);
        chk("reset_err", bus_err, 0);
        rst = 0;
        step();

        // PC increment with no memory access
        ps = 2'b01;
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk("pc_busy", busy, 0);
            step();
            chk("pc_inc", pc_out, 32'(4 * i));
        end
        chk("pc_sf", sf, 0);
        idle();

        // Add / subtract through the register file
        wr_k(5'd3, 64'd5);
        rd("r3_load", 5'd3, 64'd5);
        sa = 3; sb = 3; fs = 4'd4; c0 = 0; k_sel = 0; sl = 1; rw = 1; da = 4;
        step();
        chk("add_sf", sf, 4'b0000);
        idle();
        rd("add_res", 5'd4, 64'd10);
        sa = 3; sb = 3; fs = 4'd5; c0 = 1; sl = 1;
        step();
        chk("sub_sf", sf, 4'b0101);
        idle();

        foreach (vecs[i]) begin
            wr_k(5'd1, vecs[i].a);
            sa = 1; k_sel = 1; k = vecs[i].b; fs = vecs[i].fs; c0 = vecs[i].c0;
            rw = 1; da = 2; sl = 1;
            step();
            idle();
            chk($sformatf("vec%0d_sf", i), sf, vecs[i].f);
            rd($sformatf("vec%0d_res", i), 5'd2, vecs[i].r);
        end
        idle();

        // Read with three wait states, IR load on the ack edge
        ds = 2'b11; il = 1; ps = 2'b01; mem_rdata = 64'hDEAD_BEEF_A5A5_1234;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rd_busy", busy, 1);
            chk("rd_req", mem_req, 1);
            chk("rd_pc_hold", pc_out, 12);
            chk("rd_ir_hold", ir_out, 0);
            step();
        end
        mem_ack = 1;
        #1;
        chk("rd_ack_busy", busy, 0);
        step();
        chk("rd_ir", ir_out, 32'hA5A5_1234);
        chk("rd_pc", pc_out, 16);
        idle();

        // Zero-wait write
        mw = 1; sb = 3; as_s = 1; k_sel = 1; fs = 4'd8; k = 64'h100; mem_ack = 1; ps = 2'b01;
        #1;
        chk("wr_req", mem_req, 1);
        chk("wr_we", mem_we, 1);
        chk("wr_wdata", mem_wdata, 5);
        chk("wr_addr", mem_addr, 32'h100);
        chk("wr_busy", busy, 0);
        step();
        chk("wr_pc", pc_out, 20);
        idle();

        // Timeout abort
        ds = 2'b11; rw = 1; da = 7;
        for (int i = 0; i < 15; i++) begin
            #1;
            chk($sformatf("to_busy%0d", i), busy, 1);
            step();
        end
        #1;
        chk("to_abort_busy", busy, 0);
        chk("to_abort_req", mem_req, 0);
        step();
        chk("to_err", bus_err, 1);
        chk("to_pc", pc_out, 20);
        idle();
        rd("to_r7", 5'd7, 64'hFFFF_FFFF_FFFF_FFFF);
        ps = 2'b01;
        step();
        chk("to_next_pc", pc_out, 24);
        chk("to_err_sticky", bus_err, 1);
        idle();

        // Reset in the middle of a wait
        ds = 2'b11;
        step();
        step();
        rst = 1;
        #1;
        chk("rst_pc", pc_out, 0);
        chk("rst_sf", sf, 0);
        chk("rst_ir", ir_out, 0);
        chk("rst_err", bus_err, 0);
        idle();
        #1;
        chk("rst_req", mem_req, 0);
        step();
        rst = 0;
        step();
        wr_k(5'd0, 64'h1234);
        rd("r0_zero", 5'd0, 0);
        rd("rst_r3", 5'd3, 0);
        rd("rst_r7", 5'd7, 0);
        idle();

        // Random instructions against the model
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        m_pc = 0; m_ir = 0; m_sf = 0; m_err = 0;
        for (int it = 0; it < 300; it++) begin
            logic [63:0] a, b, bop, res, d;
            logic [3:0]  fl;
            logic [31:0] pin, exp_addr;
            logic        mop;
            int          dly;
            ps = 2'($urandom_range(0, 3)); pc_sel = 1'($urandom); k_sel = 1'($urandom);
            il = 1'($urandom); sl = 1'($urandom); fs = 4'($urandom_range(0, 15));
            c0 = 1'($urandom); rw = 1'($urandom); as_s = 1'($urandom);
            da = 5'($urandom_range(0, 7)); sa = 5'($urandom_range(0, 7));
            sb = 5'($urandom_range(0, 7));
            k = {$urandom, $urandom}; mem_rdata = {$urandom, $urandom};
            ds = 2'($urandom_range(0, 3)); mw = ($urandom_range(0, 7) == 0);
            mop = (ds == 2'b11) || mw;
            dly = mop ? int'($urandom_range(0, 3)) : 0;
            mem_ack = mop && (dly == 0);

            a = (sa == 0) ? 64'd0 : m_regs[sa];
            b = (sb == 0) ? 64'd0 : m_regs[sb];
            bop = k_sel ? k : b;
            alu_m(a, bop, fs, c0, res, fl);
            case (ds)
                2'b00: d = res;
                2'b01: d = b;
                2'b10: d = {32'd0, m_pc};
                default: d = mem_rdata;
            endcase
            exp_addr = as_s ? res[31:0] : m_pc;
            pin = pc_sel ? k[31:0] : a[31:0];

            #1;
            chk("rnd_addr", mem_addr, exp_addr);
            chk("rnd_wdata", mem_wdata, b);
            chk("rnd_req", mem_req, mop);
            chk("rnd_we", mem_we, mw);
            chk("rnd_busy0", busy, mop && (dly > 0));
            for (int w = 1; w <= dly; w++) begin
                step();
                chk("rnd_pc_hold", pc_out, m_pc);
                mem_ack = (w == dly);
                #1;
                chk("rnd_busy", busy, w < dly);
            end
            step();

            if (rw && da != 0) m_regs[da] = d;
            if (il) m_ir = d[31:0];
            if (sl) m_sf = fl;
            case (ps)
                2'b01: m_pc = m_pc + 4;
                2'b10: m_pc = pin;
                2'b11: m_pc = m_pc + 4 + pin * 4;
                default: m_pc = m_pc;
            endcase
            chk("rnd_pc", pc_out, m_pc);
            chk("rnd_ir", ir_out, m_ir);
            chk("rnd_sf", sf, m_sf);
            chk("rnd_err", bus_err, m_err);
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
